regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with an integrated busy-bit scoreboard for the superscalar pipeline. It provides NR combinational read ports and NW prioritised write ports, with same-cycle write-to-read bypass. Per-register busy bits are set at issue and cleared at writeback, so the issue stage can stall on operands whose producers are still in flight. It sits between decode/issue and the execute stages and replaces the fixed 4-read/2-write register file.

## Interface
- `DATA_W`, 32, register width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥ 2.
- `NR`, 4, number of read ports.
- `NW`, 2, number of write ports; also the number of issue (busy-set) ports.
- `AW`, $clog2(NREGS), address width; derived, never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  NR*AW  read addresses; port i occupies bits [i*AW +: AW].
- `rd_data`  out  NR*DATA_W  read data; combinational.
- `rd_busy`  out  NR  busy bit of the register at each read address; combinational.
- `we`  in  NW  write enables.
- `wr_addr`  in  NW*AW  write addresses.
- `wr_data`  in  NW*DATA_W  write data.
- `iss_valid`  in  NW  issue strobes; each sets the busy bit of its destination.
- `iss_addr`  in  NW*AW  issue destination registers.
- `flush`  in  1  synchronous clear of every busy bit; register contents are kept.

## Operation
- Register 0 is hardwired to zero:
  - Writes to it are dropped.
  - `iss_valid` targeting it is ignored.
  - Reads of it return 0 with busy 0.
- Write priority: when several enabled ports target the same nonzero register in one cycle, the lowest port index wins and the others are dropped.
- Bypass: if read port i addresses register r, and an enabled write to r (r ≠ 0) is present in the same cycle, `rd_data[i]` returns the winning port's `wr_data` rather than the stored value.
- Busy update, per register r ≠ 0, evaluated each cycle in this priority order:
  1. `flush` → 0.
  2. Otherwise, any `iss_valid[j]` with `iss_addr[j]` = r → 1. Set wins over a same-cycle clear, because the issue represents a newer producer.
  3. Otherwise, any `we[k]` with `wr_addr[k]` = r → 0.
  4. Otherwise, hold.
- Busy bypass: `rd_busy[i]` shows the stored busy bit only. It is not forwarded from same-cycle issue or write. Issue logic combines this with its own intra-group dependency check.
- No tags are kept; one outstanding producer per register is guaranteed by the issue stage. A write to a non-busy register is legal and updates data.

## Timing
- Reset (`rst` = 0, asynchronous): all registers = 0 and all busy bits = 0, taking effect immediately.
  - While `rst` is low, `rd_data` reads 0 and `rd_busy` reads 0.
  - Writes and issues are ignored.
  - Reset asserted mid-operation discards every pending update in that cycle.
- Write latency: data is stored at the rising edge and is visible combinationally through bypass in the same cycle. Stored reads show it from the next cycle onward.
- Busy latency: a set or clear is visible on `rd_busy` in the cycle after the edge.
- Read latency: zero cycles; there is no read enable.
- Writes and issues with a 0 address are no-ops regardless of enable.
- `flush` together with `we` in the same cycle: the data write proceeds and every busy bit clears.

## Structure
- `regfile_pkg` holds:
  - the default `DATA_W`, `NREGS`, `NR` and `NW` constants;
  - a function that returns the winning write-port index and a hit flag for a given address, shared by the write path and the bypass.
- One sub-module, `rf_scoreboard`: the busy-bit array with its set/clear/flush priority logic and combinational busy read-out.
- The data array, priority write logic and bypass muxes stay in the top level.

## Test plan
- Reset with defaults: load registers 1–31 and pulse `rst` low mid-cycle → every `rd_data` = 0 and `rd_busy` = 0 immediately; register 5 still reads 0 one cycle after release.
- Write conflict:
  - Same cycle: `we` = 2'b11, both ports to r7, port 0 = 32'hAAAA_0000, port 1 = 32'h5555_1111 → r7 reads 32'hAAAA_0000 next cycle.
  - Same cycle, port 0 to r0 and port 1 to r8 (32'h1234) → r0 = 0, r8 = 32'h1234.
- Bypass: r9 = 32'h1; in one cycle, write r9 = 32'hDEAD_BEEF and read r9 on all 4 ports → all ports show 32'hDEAD_BEEF that cycle and next cycle.
- Scoreboard:
  - Issue r3 → `rd_busy` for r3 = 1 next cycle.
  - Write r3 and issue r3 in the same cycle → r3 stays busy and data updates.
  - Later write r3 alone → busy = 0.
- Flush: issue r4, r5, r6 over 3 cycles, then pulse `flush` → all busy = 0 next cycle and r4–r6 data unchanged; issuing r0 never raises busy.
- Parameter sweep with NREGS = 64, NR = 6, NW = 3, DATA_W = 64: random issue/write/read traffic checked against a reference model → no mismatch over 10k cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the write-port arbitration helper for the register file.
// win_lookup is used by both the data write path and the read bypass, so the two always agree on the winning port.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NR     = 4;
  localparam int DEF_NW     = 2;

  // Upper bounds for the arbitration helper; callers zero-extend into these.
  localparam int MAX_NW = 8;
  localparam int MAX_AW = 10;
  localparam int IDX_W  = $clog2(MAX_NW);

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } wsel_t;

  // Lowest-index enabled port writing addr wins; register 0 never hits.
  function automatic wsel_t win_lookup(
    input logic [MAX_NW-1:0]             we,
    input logic [MAX_NW-1:0][MAX_AW-1:0] wa,
    input logic [MAX_AW-1:0]             addr
  );
    wsel_t r;
    r = '0;
    if (addr != '0) begin
      for (int k = MAX_NW - 1; k >= 0; k--) begin
        if (we[k] && (wa[k] == addr)) begin
          r.hit = 1'b1;
          r.idx = IDX_W'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: flush clears all, an issue sets, a writeback clears, otherwise hold.
// Read-out shows the stored bit only; same-cycle issue/write are not forwarded.
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int NR    = 4,
  parameter int NW    = 2,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [NW-1:0]    iss_valid,
  input  logic [NW*AW-1:0] iss_addr,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin : busy_next
    logic set, clr;
    set    = 1'b0;
    clr    = 1'b0;
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      set = 1'b0;
      clr = 1'b0;
      for (int j = 0; j < NW; j++) begin
        if (iss_valid[j] && (iss_addr[j*AW +: AW] == AW'(r))) set = 1'b1;
        if (we[j] && (wr_addr[j*AW +: AW] == AW'(r)))         clr = 1'b1;
      end
      // A same-cycle issue is a newer producer, so set beats clear.
      if (flush)    busy_d[r] = 1'b0;
      else if (set) busy_d[r] = 1'b1;
      else if (clr) busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NR; i++) rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with prioritised writes, same-cycle write-to-read bypass
// and an integrated busy-bit scoreboard. Register 0 reads as zero and is never busy.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  NREGS  = DEF_NREGS,
  parameter int  NR     = DEF_NR,
  parameter int  NW     = DEF_NW,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR*AW-1:0]     rd_addr,
  output logic [NR*DATA_W-1:0] rd_data,
  output logic [NR-1:0]        rd_busy,
  input  logic [NW-1:0]        we,
  input  logic [NW*AW-1:0]     wr_addr,
  input  logic [NW*DATA_W-1:0] wr_data,
  input  logic [NW-1:0]        iss_valid,
  input  logic [NW*AW-1:0]     iss_addr,
  input  logic                 flush
);

  logic [MAX_NW-1:0]             we_x;
  logic [MAX_NW-1:0][MAX_AW-1:0] wa_x;
  logic [MAX_NW-1:0][DATA_W-1:0] wd_x;
  logic [NREGS-1:0][DATA_W-1:0]  mem_q, mem_d;

  always_comb begin
    we_x = '0;
    wa_x = '0;
    wd_x = '0;
    for (int k = 0; k < NW; k++) begin
      we_x[k] = we[k];
      wa_x[k] = MAX_AW'(wr_addr[k*AW +: AW]);
      wd_x[k] = wr_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin : wr_path
    wsel_t ws;
    ws    = '0;
    mem_d = mem_q;
    for (int r = 1; r < NREGS; r++) begin
      ws = win_lookup(we_x, wa_x, MAX_AW'(r));
      if (ws.hit) mem_d[r] = wd_x[ws.idx];
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  // Bypass is gated by reset so reads stay zero while rst is held low.
  always_comb begin : rd_mux
    logic [AW-1:0] ra;
    wsel_t         rs;
    ra      = '0;
    rs      = '0;
    rd_data = '0;
    for (int i = 0; i < NR; i++) begin
      ra = rd_addr[i*AW +: AW];
      rs = win_lookup(we_x, wa_x, MAX_AW'(ra));
      if (rs.hit && rst) rd_data[i*DATA_W +: DATA_W] = wd_x[rs.idx];
      else               rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
    end
  end

  rf_scoreboard #(
    .NREGS(NREGS),
    .NR   (NR),
    .NW   (NW),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .we       (we),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table on the default configuration, a reset
// sequence, and random traffic on a 64x64b/6R/3W build checked against a reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // default configuration
  logic [19:0]  rd_addr0;
  logic [127:0] rd_data0;
  logic [3:0]   rd_busy0;
  logic [1:0]   we0, iss_valid0;
  logic [9:0]   wr_addr0, iss_addr0;
  logic [63:0]  wr_data0;
  logic         flush0;

  regfile_sb dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .we(we0), .wr_addr(wr_addr0), .wr_data(wr_data0), .iss_valid(iss_valid0),
    .iss_addr(iss_addr0), .flush(flush0)
  );

  // wide configuration
  localparam int NR1 = 6, NW1 = 3, DW1 = 64, NREG1 = 64, AW1 = 6;
  logic [NR1*AW1-1:0] rd_addr1;
  logic [NR1*DW1-1:0] rd_data1;
  logic [NR1-1:0]     rd_busy1;
  logic [NW1-1:0]     we1, iss_valid1;
  logic [NW1*AW1-1:0] wr_addr1, iss_addr1;
  logic [NW1*DW1-1:0] wr_data1;
  logic               flush1;

  regfile_sb #(.DATA_W(DW1), .NREGS(NREG1), .NR(NR1), .NW(NW1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .we(we1), .wr_addr(wr_addr1), .wr_data(wr_data1), .iss_valid(iss_valid1),
    .iss_addr(iss_addr1), .flush(flush1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Packed lists below are written port 3 first, port 0 last.
  typedef struct packed {
    logic [1:0]        we;
    logic [4:0]        wa0;
    logic [31:0]       wd0;
    logic [4:0]        wa1;
    logic [31:0]       wd1;
    logic [1:0]        iv;
    logic [4:0]        ia0;
    logic [4:0]        ia1;
    logic              fl;
    logic [3:0][4:0]   ra;
    logic [3:0][31:0]  ed;
    logic [3:0]        eb;
  } vec_t;

  typedef struct {
    logic [3:0][31:0] d;
    logic [3:0]       b;
  } exp0_t;

  typedef struct {
    logic [NR1-1:0][DW1-1:0] d;
    logic [NR1-1:0]          b;
  } exp1_t;

  localparam int NV = 24;
  vec_t  vt [NV];
  exp0_t q0 [$];
  exp1_t q1 [$];

  // reference model for the wide configuration
  logic [DW1-1:0] m_mem  [NREG1];
  logic           m_busy [NREG1];

  task automatic apply0(input vec_t v);
    we0 = v.we; wr_addr0 = {v.wa1, v.wa0}; wr_data0 = {v.wd1, v.wd0};
    iss_valid0 = v.iv; iss_addr0 = {v.ia1, v.ia0}; flush0 = v.fl; rd_addr0 = v.ra;
  endtask

  function automatic logic [5:0] raddr();
    if ($urandom_range(0, 1) == 1) return 6'($urandom_range(0, 7));
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic model_step();
    logic written [NREG1];
    logic set, clr;
    for (int r = 0; r < NREG1; r++) written[r] = 1'b0;
    for (int k = 0; k < NW1; k++) begin
      int a;
      a = int'(wr_addr1[k*AW1 +: AW1]);
      if (we1[k] && a != 0 && !written[a]) begin
        m_mem[a]   = wr_data1[k*DW1 +: DW1];
        written[a] = 1'b1;
      end
    end
    for (int r = 1; r < NREG1; r++) begin
      set = 1'b0;
      clr = 1'b0;
      for (int k = 0; k < NW1; k++) begin
        if (iss_valid1[k] && int'(iss_addr1[k*AW1 +: AW1]) == r) set = 1'b1;
        if (we1[k] && int'(wr_addr1[k*AW1 +: AW1]) == r)         clr = 1'b1;
      end
      if (flush1)   m_busy[r] = 1'b0;
      else if (set) m_busy[r] = 1'b1;
      else if (clr) m_busy[r] = 1'b0;
    end
  endtask

  function automatic exp1_t model_read();
    exp1_t e;
    for (int i = 0; i < NR1; i++) begin
      int   a;
      logic found;
      a      = int'(rd_addr1[i*AW1 +: AW1]);
      found  = 1'b0;
      e.d[i] = m_mem[a];
      for (int k = 0; k < NW1; k++) begin
        if (!found && a != 0 && we1[k] && int'(wr_addr1[k*AW1 +: AW1]) == a) begin
          e.d[i] = wr_data1[k*DW1 +: DW1];
          found  = 1'b1;
        end
      end
      if (a == 0) e.d[i] = '0;
      e.b[i] = (a == 0) ? 1'b0 : m_busy[a];
    end
    return e;
  endfunction

  initial begin
    exp0_t e0;
    exp1_t e1;
    rst = 1'b0;
    apply0('0);
    rd_addr1 = '0; we1 = '0; wr_addr1 = '0; wr_data1 = '0;
    iss_valid1 = '0; iss_addr1 = '0; flush1 = 1'b0;
    for (int r = 0; r < NREG1; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end

    // we, wa0, wd0, wa1, wd1, iv, ia0, ia1, fl, ra{p3..p0}, ed{p3..p0}, eb
    vt[0]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd3,5'd2,5'd1}, {32'h0,32'h0,32'h0,32'h0}, 4'b0000};
    vt[1]  = '{2'b11, 5'd7, 32'hAAAA_0000, 5'd7, 32'h5555_1111, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd7}, {32'h0,32'h0,32'h0,32'hAAAA_0000}, 4'b0000};
    vt[2]  = '{2'b11, 5'd0, 32'hFFFF_FFFF, 5'd8, 32'h1234, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd8,5'd0,5'd7}, {32'h0,32'h1234,32'h0,32'hAAAA_0000}, 4'b0000};
    vt[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd8,5'd7}, {32'h0,32'h0,32'h1234,32'hAAAA_0000}, 4'b0000};
    vt[4]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h1, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h0,32'h1}, 4'b0000};
    vt[5]  = '{2'b01, 5'd9, 32'hDEAD_BEEF, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd9,5'd9,5'd9,5'd9}, {32'hDEAD_BEEF,32'hDEAD_BEEF,32'hDEAD_BEEF,32'hDEAD_BEEF}, 4'b0000};
    vt[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd9,5'd9,5'd9,5'd9}, {32'hDEAD_BEEF,32'hDEAD_BEEF,32'hDEAD_BEEF,32'hDEAD_BEEF}, 4'b0000};
    vt[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd3}, {32'h0,32'h0,32'h0,32'h0}, 4'b0000};
    vt[8]  = '{2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 2'b10, 5'd0, 5'd3, 1'b0, {5'd0,5'd0,5'd0,5'd3}, {32'h0,32'h0,32'h0,32'h33}, 4'b0001};
    vt[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd3}, {32'h0,32'h0,32'h0,32'h33}, 4'b0001};
    vt[10] = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h44, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd3}, {32'h0,32'h0,32'h0,32'h44}, 4'b0001};
    vt[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd3}, {32'h0,32'h0,32'h0,32'h44}, 4'b0000};
    vt[12] = '{2'b11, 5'd4, 32'h4, 5'd5, 32'h5, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd5,5'd4}, {32'h0,32'h0,32'h5,32'h4}, 4'b0000};
    vt[13] = '{2'b01, 5'd6, 32'h6, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd6,5'd5,5'd4}, {32'h0,32'h6,32'h5,32'h4}, 4'b0000};
    vt[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd4, 5'd0, 1'b0, {5'd0,5'd6,5'd5,5'd4}, {32'h0,32'h6,32'h5,32'h4}, 4'b0000};
    vt[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0, 1'b0, {5'd0,5'd6,5'd5,5'd4}, {32'h0,32'h6,32'h5,32'h4}, 4'b0001};
    vt[16] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd6, 5'd0, 1'b0, {5'd0,5'd6,5'd5,5'd4}, {32'h0,32'h6,32'h5,32'h4}, 4'b0011};
    vt[17] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, {5'd0,5'd6,5'd5,5'd4}, {32'h0,32'h6,32'h5,32'h4}, 4'b0111};
    vt[18] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd6,5'd5,5'd4}, {32'h0,32'h6,32'h5,32'h4}, 4'b0000};
    vt[19] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd10, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd10}, {32'h0,32'h0,32'h0,32'h0}, 4'b0000};
    vt[20] = '{2'b01, 5'd10, 32'hAB, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, {5'd0,5'd0,5'd0,5'd10}, {32'h0,32'h0,32'h0,32'hAB}, 4'b0001};
    vt[21] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd10}, {32'h0,32'h0,32'h0,32'hAB}, 4'b0000};
    vt[22] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd11, 5'd0, 1'b1, {5'd0,5'd0,5'd0,5'd11}, {32'h0,32'h0,32'h0,32'h0}, 4'b0000};
    vt[23] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, {5'd0,5'd0,5'd0,5'd11}, {32'h0,32'h0,32'h0,32'h0}, 4'b0000};

    #12 rst = 1'b1;

    for (int n = 0; n < NV; n++) begin
      @(posedge clk); #1;
      apply0(vt[n]);
      q0.push_back('{vt[n].ed, vt[n].eb});
      @(negedge clk);
      if (q0.size() == 0) begin
        chk($sformatf("v%0d.queue_empty", n), 64'd1, 64'd0);
      end else begin
        e0 = q0.pop_front();
        for (int p = 0; p < 4; p++) begin
          chk($sformatf("v%0d.data%0d", n, p), 64'(rd_data0[p*32 +: 32]), 64'(e0.d[p]));
          chk($sformatf("v%0d.busy%0d", n, p), 64'(rd_busy0[p]), 64'(e0.b[p]));
        end
      end
    end

    // Load r1..r31 (i -> i*0x01010101), mark r5 busy, then reset mid-cycle.
    for (int i = 1; i < 32; i += 2) begin
      @(posedge clk); #1;
      we0      = 2'b11;
      wr_addr0 = {5'(i + 1), 5'(i)};
      wr_data0 = {32'(i + 1) * 32'h0101_0101, 32'(i) * 32'h0101_0101};
    end
    @(posedge clk); #1;
    we0 = 2'b00; iss_valid0 = 2'b01; iss_addr0 = 10'd5;
    @(posedge clk); #1;
    iss_valid0 = 2'b00; rd_addr0 = {5'd1, 5'd31, 5'd6, 5'd5};
    @(negedge clk);
    chk("load.r5", 64'(rd_data0[31:0]), 64'h0505_0505);
    chk("load.r31", 64'(rd_data0[95:64]), 64'h1F1F_1F1F);
    chk("load.busy5", 64'(rd_busy0[0]), 64'd1);
    #2;
    rst = 1'b0;
    we0 = 2'b01; wr_addr0 = 10'd5; wr_data0 = 64'hFFFF_FFFF;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst.data%0d", p), 64'(rd_data0[p*32 +: 32]), 64'd0);
      chk($sformatf("rst.busy%0d", p), 64'(rd_busy0[p]), 64'd0);
    end
    #1 we0 = 2'b00;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst.r5", 64'(rd_data0[31:0]), 64'd0);
    chk("post_rst.busy5", 64'(rd_busy0[0]), 64'd0);
    chk("post_rst.r31", 64'(rd_data0[95:64]), 64'd0);

    // Random traffic on the wide configuration; model state is zero after reset.
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      if (c > 0) model_step();
      #1;
      for (int k = 0; k < NW1; k++) begin
        we1[k]                  = ($urandom_range(0, 3) == 0);
        wr_addr1[k*AW1 +: AW1]  = raddr();
        wr_data1[k*DW1 +: DW1]  = {$urandom, $urandom};
        iss_valid1[k]           = ($urandom_range(0, 3) == 0);
        iss_addr1[k*AW1 +: AW1] = raddr();
      end
      flush1 = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NR1; i++) rd_addr1[i*AW1 +: AW1] = raddr();
      q1.push_back(model_read());
      @(negedge clk);
      e1 = q1.pop_front();
      for (int i = 0; i < NR1; i++) begin
        chk($sformatf("rnd%0d.data%0d", c, i), rd_data1[i*DW1 +: DW1], e1.d[i]);
        chk($sformatf("rnd%0d.busy%0d", c, i), 64'(rd_busy1[i]), 64'(e1.b[i]));
      end
    end
    @(posedge clk); #1;
    we1 = '0; iss_valid1 = '0; flush1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
